// File: rtl/rcu_pkg.sv
// Shared types and constants for the USB receiver control unit.
// The state enum is 4-bit encoded; RCU_SYNC_BYTE is the expected sync pattern.
package rcu_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        RCV_SYNC = 4'd2,
        CHK_SYNC = 4'd3,
        RCV_DATA = 4'd4,
        STORE    = 4'd5,
        CHK_EOP  = 4'd6,
        EOP_WAIT = 4'd7,
        ERR_EOP  = 4'd8,
        ERR_EDGE = 4'd9,
        ERR_IDLE = 4'd10
    } rcu_state_t;

    localparam logic [7:0] RCU_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/rcu.sv
// Receiver control unit: Moore FSM that frames a USB packet (sync, data bytes, EOP)
// and raises a FIFO write strobe per data byte or a sticky error on a malformed packet.
module rcu
    import rcu_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = RCU_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    rcu_state_t r_state;
    rcu_state_t w_nextState;
    logic       w_eopSample;

    assign w_eopSample = eop && shift_enable;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outputs decode r_state only; inputs steer nothing but the next state.
    always_comb begin
        w_nextState = r_state;
        rcving      = 1'b0;
        w_enable    = 1'b0;
        r_error     = 1'b0;

        case (r_state)
            IDLE: begin
                if (d_edge) w_nextState = START;
            end
            START: begin
                rcving      = 1'b1;
                w_nextState = RCV_SYNC;
            end
            RCV_SYNC: begin
                rcving = 1'b1;
                if (byte_received)    w_nextState = CHK_SYNC;
                else if (w_eopSample) w_nextState = ERR_EDGE;
            end
            CHK_SYNC: begin
                rcving      = 1'b1;
                w_nextState = (rcv_data == SYNC_BYTE) ? RCV_DATA : ERR_EOP;
            end
            RCV_DATA: begin
                // A completed byte beats a simultaneous EOP so the byte is not lost.
                rcving = 1'b1;
                if (byte_received)    w_nextState = STORE;
                else if (w_eopSample) w_nextState = ERR_EDGE;
            end
            STORE: begin
                rcving      = 1'b1;
                w_enable    = 1'b1;
                w_nextState = CHK_EOP;
            end
            CHK_EOP: begin
                rcving = 1'b1;
                if (w_eopSample)        w_nextState = EOP_WAIT;
                else if (byte_received) w_nextState = STORE;
                else                    w_nextState = RCV_DATA;
            end
            EOP_WAIT: begin
                rcving = 1'b1;
                if (d_edge) w_nextState = IDLE;
            end
            ERR_EOP: begin
                rcving  = 1'b1;
                r_error = 1'b1;
                if (w_eopSample) w_nextState = ERR_EDGE;
            end
            ERR_EDGE: begin
                rcving  = 1'b1;
                r_error = 1'b1;
                if (d_edge) w_nextState = ERR_IDLE;
            end
            ERR_IDLE: begin
                r_error = 1'b1;
                if (d_edge) w_nextState = START;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rcu.sv
// Self-checking bench for rcu: a queue predicts the cycle of each w_enable pulse,
// and direct checks cover reset, error paths and output decoding per state.
module tb_rcu;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int sbQ[$];
    int expCycle;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    rcu #(.SYNC_BYTE(8'h80)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, optionally predicting a w_enable pulse one cycle later.
    task automatic applyStimulus(input logic de, input logic eo, input logic se,
                                 input logic br, input logic [7:0] data,
                                 input logic pushExp);
        d_edge        = de;
        eop           = eo;
        shift_enable  = se;
        byte_received = br;
        rcv_data      = data;
        if (pushExp) sbQ.push_back(cycle + 1);
        @(posedge clk);
        #1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rcv_data, 1'b0);
    endtask

    always @(negedge clk) begin
        if (w_enable === 1'b1) begin
            if (sbQ.size() > 0) begin
                expCycle = sbQ.pop_front();
                checkOutput("wenLatency", cycle, expCycle);
            end else begin
                checkOutput("wenUnexpected", {31'd0, w_enable}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
        byte_received = 1'b0; rcv_data = 8'h00;

        #2;
        checkOutput("rstRcving", rcving, 0);
        checkOutput("rstWen", w_enable, 0);
        checkOutput("rstErr", r_error, 0);

        // d_edge present at reset release must not act before the next rising edge.
        @(posedge clk); #1;
        d_edge = 1'b1;
        #2 n_rst = 1'b1;
        #1 checkOutput("releaseHold", rcving, 0);
        @(posedge clk); #1;
        d_edge = 1'b0;
        checkOutput("startRcving", rcving, 1);
        checkOutput("startErr", r_error, 0);

        // Good packet: sync, 0xA5, 0x3C, EOP, return to idle.
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h80, 0);
        checkOutput("chkSyncErr", r_error, 0);
        idleCycle();
        checkOutput("dataRcving", rcving, 1);
        checkOutput("dataErr", r_error, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 8'h80, 0);
        applyStimulus(0, 0, 0, 1, 8'hA5, 1);
        checkOutput("storeWen", w_enable, 1);
        idleCycle();
        checkOutput("chkEopWen", w_enable, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h3C, 1);
        idleCycle();
        applyStimulus(0, 1, 1, 0, 8'h3C, 0);
        checkOutput("eopWaitRcving", rcving, 1);
        checkOutput("eopWaitErr", r_error, 0);
        idleCycle();
        applyStimulus(1, 0, 0, 0, 8'h3C, 0);
        checkOutput("pktDoneRcving", rcving, 0);
        checkOutput("pktDoneErr", r_error, 0);

        // Bad sync byte.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h81, 0);
        checkOutput("badSyncChkErr", r_error, 0);
        idleCycle();
        checkOutput("errEopErr", r_error, 1);
        checkOutput("errEopRcving", rcving, 1);
        applyStimulus(1, 0, 0, 1, 8'h81, 0);
        checkOutput("errEopIgnore", r_error, 1);
        applyStimulus(0, 1, 1, 0, 8'h81, 0);
        checkOutput("errEdgeErr", r_error, 1);
        checkOutput("errEdgeRcving", rcving, 1);
        applyStimulus(1, 0, 0, 0, 8'h81, 0);
        checkOutput("errIdleErr", r_error, 1);
        checkOutput("errIdleRcving", rcving, 0);
        idleCycle();
        checkOutput("errIdleHold", r_error, 1);

        // Recovery from ERR_IDLE.
        applyStimulus(1, 0, 0, 0, 8'h81, 0);
        checkOutput("recoverErr", r_error, 0);
        checkOutput("recoverRcving", rcving, 1);

        // Partial data byte terminated by EOP.
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h80, 0);
        idleCycle();
        repeat (4) applyStimulus(0, 0, 1, 0, 8'h80, 0);
        applyStimulus(0, 1, 1, 0, 8'h80, 0);
        checkOutput("partialErr", r_error, 1);
        checkOutput("partialRcving", rcving, 1);
        applyStimulus(1, 0, 0, 0, 8'h80, 0);
        checkOutput("partialIdleRcving", rcving, 0);
        applyStimulus(1, 0, 0, 0, 8'h80, 0);

        // byte_received coincident with EOP in RCV_DATA: byte is stored, then CHK_EOP.
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h80, 0);
        idleCycle();
        applyStimulus(0, 1, 1, 1, 8'h5A, 1);
        checkOutput("coincWen", w_enable, 1);
        checkOutput("coincErr", r_error, 0);
        idleCycle();
        checkOutput("coincChkEopWen", w_enable, 0);
        applyStimulus(0, 1, 1, 0, 8'h5A, 0);
        checkOutput("coincEopErr", r_error, 0);
        checkOutput("coincEopRcving", rcving, 1);
        applyStimulus(1, 0, 0, 0, 8'h5A, 0);
        checkOutput("coincIdleRcving", rcving, 0);

        // Asynchronous reset in the middle of RCV_DATA with a byte pending.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h80, 0);
        idleCycle();
        byte_received = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midRstRcving", rcving, 0);
        checkOutput("midRstWen", w_enable, 0);
        checkOutput("midRstErr", r_error, 0);
        @(posedge clk); #1;
        checkOutput("midRstHoldWen", w_enable, 0);
        byte_received = 1'b0;
        #2 n_rst = 1'b1;
        #1 checkOutput("midRstRelRcving", rcving, 0);
        idleCycle();
        checkOutput("midRstIdleRcving", rcving, 0);
        checkOutput("midRstIdleWen", w_enable, 0);

        // Asynchronous reset while in ERR_EOP.
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 8'h81, 0);
        idleCycle();
        checkOutput("preRstErr", r_error, 1);
        #1 n_rst = 1'b0;
        #1;
        checkOutput("errRstErr", r_error, 0);
        checkOutput("errRstRcving", rcving, 0);
        #1 n_rst = 1'b1;
        idleCycle();
        checkOutput("errRstIdleErr", r_error, 0);
        checkOutput("errRstIdleRcving", rcving, 0);

        repeat (3) idleCycle();
        checkOutput("wenPending", sbQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcu.md
RCU -- requirements
Module: rcu

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h80, meaning the required first received byte (sync pattern, LSB-first shifted).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port d_edge, input, 1, one-cycle pulse on any D+ transition from the edge detector.
REQ-005 SHALL have port eop, input, 1, end-of-packet line condition (D+ and D- both low), sampled only when shift_enable=1.
REQ-006 SHALL have port shift_enable, input, 1, one-cycle bit-sample strobe from the bit timer.
REQ-007 SHALL have port byte_received, input, 1, one-cycle pulse when 8 bits have been shifted in.
REQ-008 SHALL have port rcv_data, input, 8, current shift-register byte; valid in the cycle after byte_received.
REQ-009 SHALL have port rcving, output, 1, high while a packet is being received.
REQ-010 SHALL have port w_enable, output, 1, one-cycle FIFO write strobe per data byte.
REQ-011 SHALL have port r_error, output, 1, sticky receive-error flag.

Function
REQ-012 SHALL be a Moore FSM; all outputs are decoded from the registered state only, with no input-to-output combinational path.
REQ-013 SHALL implement states IDLE, START, RCV_SYNC, CHK_SYNC, RCV_DATA, STORE, CHK_EOP, EOP_WAIT, ERR_EOP, ERR_EDGE, ERR_IDLE.
REQ-014 IDLE: on d_edge go to START; otherwise stay. Outputs: rcving=0, w_enable=0, r_error=0.
REQ-015 START: lasts one cycle with r_error=0 and rcving=1, then unconditionally go to RCV_SYNC.
REQ-016 RCV_SYNC: on byte_received go to CHK_SYNC.
REQ-017 RCV_SYNC: on eop&&shift_enable without byte_received, go to ERR_EDGE.
REQ-018 CHK_SYNC: lasts one cycle; if rcv_data==SYNC_BYTE go to RCV_DATA, else go to ERR_EOP.
REQ-019 RCV_DATA: on byte_received go to STORE.
REQ-020 RCV_DATA: on eop&&shift_enable without byte_received (partial byte), go to ERR_EDGE.
REQ-021 RCV_DATA: if byte_received and eop&&shift_enable occur in the same cycle, byte_received SHALL win.
REQ-022 STORE: lasts exactly one cycle with w_enable=1, then go to CHK_EOP.
REQ-023 CHK_EOP: on eop&&shift_enable go to EOP_WAIT; on byte_received go to STORE; otherwise go to RCV_DATA.
REQ-024 EOP_WAIT: on d_edge (line return to idle J) go to IDLE.
REQ-025 ERR_EOP: wait for eop&&shift_enable, then go to ERR_EDGE.
REQ-026 ERR_EDGE: on d_edge go to ERR_IDLE.
REQ-027 ERR_IDLE: r_error=1 and rcving=0; on d_edge go to START, which clears r_error.
REQ-028 rcving SHALL be 1 in START, RCV_SYNC, CHK_SYNC, RCV_DATA, STORE, CHK_EOP, EOP_WAIT, ERR_EOP and ERR_EDGE, and 0 in IDLE and ERR_IDLE.
REQ-029 r_error SHALL be 1 in ERR_EOP, ERR_EDGE and ERR_IDLE, and 0 in all other states.
REQ-030 w_enable SHALL be 1 only in STORE; it never asserts for the sync byte or on an error path.
REQ-031 Latency: w_enable SHALL assert 1 cycle after byte_received (RCV_DATA->STORE); CHK_SYNC decides 1 cycle after byte_received.
REQ-032 d_edge, byte_received and eop SHALL be ignored in every state not listed as reacting to them.

Reset
REQ-033 n_rst=0 SHALL asynchronously force state IDLE, giving rcving=0, w_enable=0, r_error=0 immediately, including when asserted mid-packet or mid-error.
REQ-034 On reset release, the first transition SHALL occur no earlier than the next rising clk edge.

Structure
REQ-035 Shared package rcu_pkg SHALL hold the state enum type (4-bit encoding) and the SYNC_BYTE constant 8'h80.
REQ-036 SHALL be a single module with no sub-modules: one always_ff state register and one always_comb next-state/output block.

Verification
REQ-037 Reset mid-RCV_DATA -> outputs 0 asynchronously, state IDLE, no w_enable.
REQ-038 d_edge, then byte_received with rcv_data=8'h80, then 2 bytes (8'hA5, 8'h3C) with byte_received each, then eop&&shift_enable, then d_edge -> exactly 2 w_enable pulses, each 1 cycle after byte_received; r_error=0 throughout; rcving falls after the final d_edge.
REQ-039 Sync byte 8'h81 -> no w_enable, r_error=1 from the cycle after CHK_SYNC; after eop&&shift_enable and d_edge, ERR_IDLE holds r_error=1 and rcving=0.
REQ-040 From ERR_IDLE, d_edge -> r_error=0 and rcving=1 in the next cycle.
REQ-041 eop&&shift_enable after 4 bits of a data byte -> r_error=1, no w_enable for the partial byte.
REQ-042 byte_received coincident with eop&&shift_enable in RCV_DATA -> STORE taken (w_enable=1), then CHK_EOP.
